// File: rtl/dmem_pkg.sv
// dmem_pkg: FSM states, RV32I load/store funct3 codes and request legality check
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;
  // funct3[1:0] encodes size for both loads and stores: 0=byte, 1=half, 2=word
  function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] boff);
    logic f3_ok, algn;
    f3_ok = we ? f3 inside {SB, SH, SW} : f3 inside {LB, LH, LW, LBU, LHU};
    algn = f3[1:0] == 2'd0 || (f3[1:0] == 2'd1 && !boff[0]) || (f3[1:0] == 2'd2 && boff == 2'd0);
    return f3_ok && algn;
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port DEPTH x 32 RAM, 1-cycle synchronous read, word-wide write
module dmem_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data-memory responder; read-modify-write stores, extended loads
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [1:0]  req_boff,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q;
  logic we_q, err_q, acc_ok, accept, ram_en, ram_we;
  logic [AW-1:0] addr_q, ram_addr;
  logic [1:0] boff_q;
  logic [2:0] f3_q;
  logic [31:0] wdata_q, rdata_q, ram_rdata, wsh, merge_d, load_d;
  logic [3:0] be;
  logic [7:0] b;
  logic [15:0] h;
  assign req_ready = state_q == IDLE;
  assign accept = req_valid & req_ready;
  assign acc_ok = access_ok(req_we, req_funct3, req_boff);
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  // RAM output register holds the read word through WRITE, so the merge reads it directly
  assign ram_en = (accept & acc_ok) | (state_q == WRITE);
  assign ram_we = state_q == WRITE;
  assign ram_addr = ram_we ? addr_q : req_addr[AW-1:0];
  always_comb begin
    wsh = wdata_q << {boff_q, 3'b000};
    be = f3_q == SW ? 4'b1111 : f3_q == SH ? 4'b0011 << boff_q : 4'b0001 << boff_q;
    merge_d = ram_rdata;
    for (int i = 0; i < 4; i++) merge_d[8*i+:8] = be[i] ? wsh[8*i+:8] : ram_rdata[8*i+:8];
    b = 8'(ram_rdata >> {boff_q, 3'b000});
    h = boff_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_d = f3_q == LB ? {{24{b[7]}}, b} : f3_q == LBU ? {24'h0, b} :
             f3_q == LH ? {{16{h[15]}}, h} : f3_q == LHU ? {16'h0, h} : ram_rdata;
  end
  dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .en(ram_en), .we(ram_we), .addr(ram_addr), .wdata(merge_d), .rdata(ram_rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      boff_q <= '0;
      f3_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          we_q <= req_we;
          addr_q <= req_addr[AW-1:0];
          boff_q <= req_boff;
          f3_q <= req_funct3;
          wdata_q <= req_wdata;
          rdata_q <= '0;
          err_q <= !acc_ok;
          state_q <= acc_ok ? READ : RESP;
        end
        READ: begin
          rdata_q <= we_q ? 32'h0 : load_d;
          state_q <= we_q ? WRITE : RESP;
        end
        WRITE: state_q <= RESP;
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (DEPTH=128 to exercise address wrap)
module tb_dmem_responder;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       tag;
  } exp_t;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0, rsp_ready = 1;
  logic req_ready, rsp_valid, rsp_err;
  logic [7:0] req_addr = 0;
  logic [1:0] req_boff = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_wdata = 0, rsp_rdata;
  int n_chk = 0, n_pass = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(128)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_boff(req_boff), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic drive(input logic we, input logic [7:0] a, input logic [1:0] bo, input logic [2:0] f3, input logic [31:0] wd);
    @(negedge clk);
    req_we = we; req_addr = a; req_boff = bo; req_funct3 = f3; req_wdata = wd; req_valid = 1;
  endtask
  task automatic do_req(input string tag, input logic we, input logic [7:0] a, input logic [1:0] bo,
                        input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] xd,
                        input logic xe, input int xl, input int hold);
    exp_t e;
    int lat;
    logic [31:0] held;
    sb.push_back('{xd, xe, xl, tag});
    rsp_ready = (hold == 0);
    drive(we, a, bo, f3, wd);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check({e.tag, ".lat"}, 32'(lat), 32'(e.lat));
    check({e.tag, ".rdata"}, rsp_rdata, e.rdata);
    check({e.tag, ".err"}, 32'(rsp_err), 32'(e.err));
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({e.tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({e.tag, ".hold_rdata"}, rsp_rdata, held);
      check({e.tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    check({e.tag, ".released"}, 32'(rsp_valid), 32'd0);
  endtask
  initial begin
    #12;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk) rst_n = 1;
    do_req("sw10",   1, 8'h10, 2'd0, 3'd2, 32'hDEADBEEF, 32'h0,        0, 3, 0);
    do_req("lw10",   0, 8'h10, 2'd0, 3'd2, 32'h0,        32'hDEADBEEF, 0, 2, 0);
    do_req("sb10",   1, 8'h10, 2'd2, 3'd0, 32'h00000080, 32'h0,        0, 3, 0);
    do_req("lb10",   0, 8'h10, 2'd2, 3'd0, 32'h0,        32'hFFFFFF80, 0, 2, 0);
    do_req("lbu10",  0, 8'h10, 2'd2, 3'd4, 32'h0,        32'h00000080, 0, 2, 0);
    do_req("lw10b",  0, 8'h10, 2'd0, 3'd2, 32'h0,        32'hDE80BEEF, 0, 2, 0);
    do_req("lh_mis", 0, 8'h10, 2'd1, 3'd1, 32'h0,        32'h0,        1, 1, 0);
    do_req("sw_mis", 1, 8'h10, 2'd2, 3'd2, 32'h11111111, 32'h0,        1, 1, 0);
    do_req("ld_f3",  0, 8'h10, 2'd0, 3'd3, 32'h0,        32'h0,        1, 1, 0);
    do_req("st_f3",  1, 8'h10, 2'd0, 3'd4, 32'h22222222, 32'h0,        1, 1, 0);
    do_req("lw_stl", 0, 8'h10, 2'd0, 3'd2, 32'h0,        32'hDE80BEEF, 0, 2, 5);
    do_req("sh10",   1, 8'h10, 2'd2, 3'd1, 32'hFFFF1234, 32'h0,        0, 3, 0);
    do_req("lh_hi",  0, 8'h10, 2'd2, 3'd1, 32'h0,        32'h00001234, 0, 2, 0);
    do_req("lh_lo",  0, 8'h10, 2'd0, 3'd1, 32'h0,        32'hFFFFBEEF, 0, 2, 0);
    do_req("lhu_lo", 0, 8'h10, 2'd0, 3'd5, 32'h0,        32'h0000BEEF, 0, 2, 0);
    do_req("sb_b3",  1, 8'h10, 2'd3, 3'd0, 32'hAAAAAA7F, 32'h0,        0, 3, 0);
    do_req("lb_b3",  0, 8'h10, 2'd3, 3'd0, 32'h0,        32'h0000007F, 0, 2, 0);
    do_req("lw10c",  0, 8'h10, 2'd0, 3'd2, 32'h0,        32'h7F34BEEF, 0, 2, 0);
    do_req("sw20",   1, 8'h20, 2'd0, 3'd2, 32'hCAFEF00D, 32'h0,        0, 3, 0);
    drive(1, 8'h20, 2'd0, 3'd2, 32'h12345678);
    @(posedge clk); #1;
    req_valid = 0;
    check("abort.in_read", 32'(req_ready), 32'd0);
    #2 rst_n = 0;
    #1;
    check("abort.req_ready", 32'(req_ready), 32'd1);
    check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort.rsp_rdata", rsp_rdata, 32'd0);
    check("abort.rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort.no_rsp", 32'(rsp_valid), 32'd0);
    do_req("lw20",   0, 8'h20, 2'd0, 3'd2, 32'h0,        32'hCAFEF00D, 0, 2, 0);
    do_req("sw_ff",  1, 8'hFF, 2'd0, 3'd2, 32'hA5A55A5A, 32'h0,        0, 3, 0);
    do_req("lw_7f",  0, 8'h7F, 2'd0, 3'd2, 32'h0,        32'hA5A55A5A, 0, 2, 0);
    do_req("sb_7f",  1, 8'h7F, 2'd0, 3'd0, 32'h000000C3, 32'h0,        0, 3, 0);
    do_req("lw_ff",  0, 8'hFF, 2'd0, 3'd2, 32'h0,        32'hA5A55AC3, 0, 2, 0);
    do_req("lw10d",  0, 8'h10, 2'd0, 3'd2, 32'h0,        32'h7F34BEEF, 0, 2, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words in data memory, addressed by req_addr.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1, meaning the core presents a load/store request.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 The block SHALL have port req_we, input, 1, meaning 1=store, 0=load.
REQ-007 The block SHALL have port req_addr, input, 8, meaning the word address.
REQ-008 The block SHALL have port req_boff, input, 2, meaning the byte offset within the word.
REQ-009 The block SHALL have port req_funct3, input, 3, meaning the RV32I load/store size and sign field.
REQ-010 The block SHALL have port req_wdata, input, 32, meaning the store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1, meaning the response is available.
REQ-012 The block SHALL have port rsp_ready, input, 1, meaning the core consumes the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32, meaning the load data after extension; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err, output, 1, meaning a misaligned access or an illegal funct3.

Function
REQ-015 The block SHALL transfer a request only when req_valid and req_ready are both 1 in the same cycle, and SHALL drive req_ready=1 only in state IDLE.
REQ-016 The block SHALL implement FSM states IDLE, READ, WRITE, RESP, and SHALL capture all req_* fields into registers on acceptance.
REQ-017 On a legal accepted request, the block SHALL transition IDLE->READ and SHALL issue a synchronous word read of req_addr.
REQ-018 From READ, a load SHALL transition to RESP and a store SHALL transition to WRITE.
REQ-019 In WRITE, the block SHALL write back the read word merged with the store lanes: SB updates byte boff; SH updates bytes boff..boff+1; SW updates all bytes. The block SHALL then transition to RESP.
REQ-020 The block SHALL hold RESP with rsp_valid=1 and stable rsp_rdata/rsp_err until rsp_ready=1, then return to IDLE on the next edge.
REQ-021 Latency from the acceptance edge SHALL be: load rsp_valid after 2 cycles; store after 3 cycles; error after 1 cycle.
REQ-022 Load extraction SHALL be: LB/LBU select byte boff with sign/zero extension; LH/LHU select half boff[1]; LW selects the whole word.
REQ-023 Legal load funct3 values SHALL be 0, 1, 2, 4, 5; legal store funct3 values SHALL be 0, 1, 2.
REQ-024 A halfword with boff[0]=1, a word with boff!=0, or an illegal funct3 SHALL go IDLE->RESP directly, with rsp_err=1, rsp_rdata=0, and no memory read or write.
REQ-025 The block SHALL wrap req_addr modulo DEPTH; addresses are never an error.
REQ-026 Back-to-back operation SHALL be supported: a request presented in the cycle RESP is left is accepted in the following IDLE cycle, giving at most one idle cycle between responses.

Reset
REQ-027 While rst_n=0, the block SHALL force state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and clear the captured request registers.
REQ-028 A reset asserted in READ or RESP SHALL discard the transaction; a reset asserted before the WRITE edge SHALL leave memory unmodified.
REQ-029 Memory contents SHALL NOT be reset.

Structure
REQ-030 Package dmem_pkg SHALL hold the FSM state encoding and the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-031 The block SHALL contain one sub-module, dmem_ram: a single-port DEPTH x 32 synchronous RAM with a 1-cycle read and a word-wide write enable.
REQ-032 Lane merge and load extension SHALL be combinational logic inside dmem_responder.

Verification
REQ-033 SW addr=0x10 boff=0 wdata=0xDEADBEEF, then LW addr=0x10 -> store response rsp_err=0 after 3 cycles; load rsp_rdata=0xDEADBEEF after 2 cycles.
REQ-034 After REQ-033, SB addr=0x10 boff=2 wdata=0x80, then LB boff=2 -> 0xFFFFFF80; LBU boff=2 -> 0x00000080; LW -> 0xDE80BEEF.
REQ-035 LH boff=1, SW boff=2, and load funct3=3 -> each gives rsp_err=1 and rsp_rdata=0 after 1 cycle; memory word 0x10 is unchanged.
REQ-036 rsp_ready held 0 for 5 cycles during a load -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; a response is released on the first rsp_ready=1.
REQ-037 rst_n pulsed low in READ of SW addr=0x20 wdata=0x12345678 -> outputs at reset values and a subsequent LW addr=0x20 returns the pre-existing value.
REQ-038 req_addr=0xFF with DEPTH=128 -> the access targets word 0x7F.
